// File: rtl/edge_bbox_pkg.sv
// Shared types and width helpers for the edge bounding-box tracker.
package edge_bbox_pkg;

    localparam int RES_COORD_W = 16;
    localparam int RES_CNT_W   = 32;

    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int col_w(input int img_w);
        return clog2_min1(img_w);
    endfunction

    function automatic int row_w(input int img_h);
        return clog2_min1(img_h);
    endfunction

    function automatic int cnt_w(input int img_w, input int img_h);
        return clog2_min1(img_w * img_h + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    typedef struct packed {
        logic [RES_COORD_W-1:0] x_min;
        logic [RES_COORD_W-1:0] x_max;
        logic [RES_COORD_W-1:0] y_min;
        logic [RES_COORD_W-1:0] y_max;
        logic [RES_CNT_W-1:0]   cnt;
        logic                   found;
    } bbox_res_t;

endpackage

// File: rtl/edge_bbox_if.sv
// Edge pixel stream in, per-frame bounding-box result out.
interface edge_bbox_if
    import edge_bbox_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
);
    localparam int COL_W = col_w(IMG_W);
    localparam int ROW_W = row_w(IMG_H);
    localparam int CNT_W = cnt_w(IMG_W, IMG_H);

    logic             din;
    logic             din_sop;
    logic             din_eop;
    logic             din_vld;
    logic [COL_W-1:0] box_x_min;
    logic [COL_W-1:0] box_x_max;
    logic [ROW_W-1:0] box_y_min;
    logic [ROW_W-1:0] box_y_max;
    logic [CNT_W-1:0] edge_cnt;
    logic             box_found;
    logic             box_vld;
    logic             frame_err;

    modport master (
        output din, din_sop, din_eop, din_vld,
        input  box_x_min, box_x_max, box_y_min, box_y_max,
        input  edge_cnt, box_found, box_vld, frame_err
    );

    modport slave (
        input  din, din_sop, din_eop, din_vld,
        output box_x_min, box_x_max, box_y_min, box_y_max,
        output edge_cnt, box_found, box_vld, frame_err
    );
endinterface

// File: rtl/edge_bbox_pix_coord_cnt.sv
// Column/row position of the current valid pixel; sop forces (0,0), counters saturate past the last line.
module pix_coord_cnt
    import edge_bbox_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    localparam int COL_W = col_w(IMG_W),
    localparam int ROW_W = row_w(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic             sop,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_pix,
    output logic             overrun
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Registers hold the position the next pixel will take.
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             ovr_q;
    logic             col_wrap;

    always_comb begin
        col      = sop ? '0 : col_q;
        row      = sop ? '0 : row_q;
        overrun  = sop ? 1'b0 : ovr_q;
        col_wrap = (col == COL_LAST);
        last_pix = !overrun && col_wrap && (row == ROW_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            ovr_q <= 1'b0;
        end else if (vld && !overrun) begin
            col_q <= col_wrap ? '0 : col + 1'b1;
            row_q <= (col_wrap && row != ROW_LAST) ? row + 1'b1 : row;
            ovr_q <= col_wrap && (row == ROW_LAST);
        end
    end
endmodule

// File: rtl/edge_bbox.sv
// Per-frame bounding box and count of edge pixels, published once per frame with a valid pulse.
// Optional EDGE_BBOX_ROI_EN: pixels within BORDER of the image edge are treated as non-edge.
module edge_bbox
    import edge_bbox_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int MIN_CNT = 16,
    parameter int BORDER  = 2
) (
    input  logic       clk,
    input  logic       rst,
    edge_bbox_if.slave bus
);
    localparam int COL_W = col_w(IMG_W);
    localparam int ROW_W = row_w(IMG_H);
    localparam int CNT_W = cnt_w(IMG_W, IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
`ifdef EDGE_BBOX_ROI_EN
    localparam bit ROI_EN = 1'b1;
`else
    localparam bit ROI_EN = 1'b0;
`endif

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_pix, overrun;
    logic             roi_ok, hit, found, take, start, pend_err;
    logic [COL_W-1:0] acc_x_min, acc_x_max, b_x_min, b_x_max, nxt_x_min, nxt_x_max;
    logic [ROW_W-1:0] acc_y_min, acc_y_max, b_y_min, b_y_max, nxt_y_min, nxt_y_max;
    logic [CNT_W-1:0] acc_cnt, b_cnt, nxt_cnt;
    bbox_res_t        res_q;
    logic             box_vld_q, frame_err_q;
    logic             unused_res_bits;

    pix_coord_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_coord (
        .clk      (clk),
        .rst      (rst),
        .vld      (bus.din_vld),
        .sop      (bus.din_sop),
        .col      (col),
        .row      (row),
        .last_pix (last_pix),
        .overrun  (overrun)
    );

    assign start = bus.din_vld && bus.din_sop;
    assign take  = bus.din_vld && (bus.din_sop || state == ACTIVE);

    // On sop the accumulators restart from their empty values with the sop pixel folded in.
    always_comb begin
        roi_ok = !ROI_EN ||
                 (int'(col) >= BORDER && int'(col) < IMG_W - BORDER &&
                  int'(row) >= BORDER && int'(row) < IMG_H - BORDER);
        hit = bus.din && !overrun && roi_ok;
        if (bus.din_sop) begin
            b_x_min = COL_LAST;
            b_x_max = '0;
            b_y_min = ROW_LAST;
            b_y_max = '0;
            b_cnt   = '0;
        end else begin
            b_x_min = acc_x_min;
            b_x_max = acc_x_max;
            b_y_min = acc_y_min;
            b_y_max = acc_y_max;
            b_cnt   = acc_cnt;
        end
        nxt_x_min = (hit && col < b_x_min) ? col : b_x_min;
        nxt_x_max = (hit && col > b_x_max) ? col : b_x_max;
        nxt_y_min = (hit && row < b_y_min) ? row : b_y_min;
        nxt_y_max = (hit && row > b_y_max) ? row : b_y_max;
        nxt_cnt   = b_cnt + CNT_W'(hit);
        found     = int'(acc_cnt) >= MIN_CNT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc_x_min   <= '0;
            acc_x_max   <= '0;
            acc_y_min   <= '0;
            acc_y_max   <= '0;
            acc_cnt     <= '0;
            pend_err    <= 1'b0;
            res_q       <= '0;
            box_vld_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            box_vld_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (take) begin
                acc_x_min <= nxt_x_min;
                acc_x_max <= nxt_x_max;
                acc_y_min <= nxt_y_min;
                acc_y_max <= nxt_y_max;
                acc_cnt   <= nxt_cnt;
                if (bus.din_eop) pend_err <= !last_pix;
            end
            case (state)
                ACTIVE: begin
                    if (bus.din_vld) begin
                        if (bus.din_sop) frame_err_q <= 1'b1;
                        if (bus.din_eop) state <= DONE;
                    end
                end
                IDLE, DONE: begin
                    if (state == DONE) begin
                        box_vld_q   <= 1'b1;
                        frame_err_q <= pend_err;
                        res_q.cnt   <= RES_CNT_W'(acc_cnt);
                        res_q.found <= found;
                        res_q.x_min <= found ? RES_COORD_W'(acc_x_min) : '0;
                        res_q.x_max <= found ? RES_COORD_W'(acc_x_max) : '0;
                        res_q.y_min <= found ? RES_COORD_W'(acc_y_min) : '0;
                        res_q.y_max <= found ? RES_COORD_W'(acc_y_max) : '0;
                    end
                    if (start) state <= bus.din_eop ? DONE : ACTIVE;
                    else       state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.box_x_min = res_q.x_min[COL_W-1:0];
    assign bus.box_x_max = res_q.x_max[COL_W-1:0];
    assign bus.box_y_min = res_q.y_min[ROW_W-1:0];
    assign bus.box_y_max = res_q.y_max[ROW_W-1:0];
    assign bus.edge_cnt  = res_q.cnt[CNT_W-1:0];
    assign bus.box_found = res_q.found;
    assign bus.box_vld   = box_vld_q;
    assign bus.frame_err = frame_err_q;

    // Result fields are sized for the largest image; the upper bits are always zero.
    assign unused_res_bits = ^{res_q.x_min >> COL_W, res_q.x_max >> COL_W,
                               res_q.y_min >> ROW_W, res_q.y_max >> ROW_W,
                               res_q.cnt >> CNT_W};
endmodule

// File: tb/tb_edge_bbox.sv
// Self-checking bench for edge_bbox: directed vector table, hand sequences and a randomized stream vs. a frame model.
module tb_edge_bbox;
    import edge_bbox_pkg::*;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int MINC = 2;
    localparam int BRD  = 1;

    typedef struct { bit din; bit sop; bit eop; } beat_t;
    typedef struct { int x_min; int x_max; int y_min; int y_max; int cnt; bit found; bit err; } res_t;
    typedef struct { string name; logic [63:0] mask; int n; int gap; res_t exp; } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   abort_pulses = 0;
    int   exp_aborts = 0;
    int   last_eop_cyc = 0;
    res_t got_q[$];
    int   got_cyc[$];
    res_t exp_q[$];
    beat_t stim_q[$];
    res_t mon_r;
    vec_t vt[8];

    edge_bbox_if #(.IMG_W(W), .IMG_H(H)) bus ();

    edge_bbox #(
        .IMG_W   (W),
        .IMG_H   (H),
        .MIN_CNT (MINC),
        .BORDER  (BRD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.box_vld) begin
                mon_r.x_min = int'(bus.box_x_min);
                mon_r.x_max = int'(bus.box_x_max);
                mon_r.y_min = int'(bus.box_y_min);
                mon_r.y_max = int'(bus.box_y_max);
                mon_r.cnt   = int'(bus.edge_cnt);
                mon_r.found = bus.box_found;
                mon_r.err   = bus.frame_err;
                got_q.push_back(mon_r);
                got_cyc.push_back(cyc);
            end else if (bus.frame_err) begin
                abort_pulses++;
            end
        end
    end

    function automatic bit in_roi(input int c, input int r);
`ifdef EDGE_BBOX_ROI_EN
        return c >= BRD && c < W - BRD && r >= BRD && r < H - BRD;
`else
        return 1'b1;
`endif
    endfunction

    // Frame-level reference: walk the accepted pixels, index -> (col,row), then reduce.
    task automatic model_run(input beat_t bs[$]);
        bit   in_f = 1'b0;
        int   idx = 0;
        int   cnt = 0, xn = W, xx = -1, yn = H, yx = -1;
        res_t r;
        foreach (bs[i]) begin
            if (bs[i].sop) begin
                if (in_f) exp_aborts++;
                in_f = 1'b1; idx = 0; cnt = 0; xn = W; xx = -1; yn = H; yx = -1;
            end else if (!in_f) begin
                continue;
            end
            if (idx < W * H && bs[i].din && in_roi(idx % W, idx / W)) begin
                cnt++;
                if (idx % W < xn) xn = idx % W;
                if (idx % W > xx) xx = idx % W;
                if (idx / W < yn) yn = idx / W;
                if (idx / W > yx) yx = idx / W;
            end
            if (bs[i].eop) begin
                r.cnt   = cnt;
                r.found = (cnt >= MINC);
                r.x_min = r.found ? xn : 0;
                r.x_max = r.found ? xx : 0;
                r.y_min = r.found ? yn : 0;
                r.y_max = r.found ? yx : 0;
                r.err   = (idx != W * H - 1);
                exp_q.push_back(r);
                in_f = 1'b0;
            end
            idx++;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t g, input res_t e);
        check($sformatf("%s.x_min", tag), g.x_min, e.x_min);
        check($sformatf("%s.x_max", tag), g.x_max, e.x_max);
        check($sformatf("%s.y_min", tag), g.y_min, e.y_min);
        check($sformatf("%s.y_max", tag), g.y_max, e.y_max);
        check($sformatf("%s.edge_cnt", tag), g.cnt, e.cnt);
        check($sformatf("%s.box_found", tag), int'(g.found), int'(e.found));
        check($sformatf("%s.frame_err", tag), int'(g.err), int'(e.err));
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s.x_min", tag), int'(bus.box_x_min), 0);
        check($sformatf("%s.x_max", tag), int'(bus.box_x_max), 0);
        check($sformatf("%s.y_min", tag), int'(bus.box_y_min), 0);
        check($sformatf("%s.y_max", tag), int'(bus.box_y_max), 0);
        check($sformatf("%s.edge_cnt", tag), int'(bus.edge_cnt), 0);
        check($sformatf("%s.box_found", tag), int'(bus.box_found), 0);
        check($sformatf("%s.box_vld", tag), int'(bus.box_vld), 0);
        check($sformatf("%s.frame_err", tag), int'(bus.frame_err), 0);
    endtask

    task automatic push_frame(input logic [63:0] mask, input int n, input bit with_eop);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.din = mask[i];
            b.sop = (i == 0);
            b.eop = with_eop && (i == n - 1);
            stim_q.push_back(b);
        end
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        bus.din_vld = 1'b0;
        bus.din     = 1'($urandom_range(0, 1));
        bus.din_sop = 1'($urandom_range(0, 1));
        bus.din_eop = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_beat(input beat_t b);
        @(posedge clk);
        #1;
        bus.din_vld = 1'b1;
        bus.din     = b.din;
        bus.din_sop = b.sop;
        bus.din_eop = b.eop;
        if (b.eop) last_eop_cyc = cyc;
    endtask

    // gap 0: continuous, 1: idle before every odd beat, 2: random idles
    task automatic run_stim(input int gap);
        foreach (stim_q[i]) begin
            if (gap == 1 && i % 2 == 1) drive_idle();
            if (gap == 2 && $urandom_range(0, 3) == 0) begin
                int k = $urandom_range(1, 2);
                repeat (k) drive_idle();
            end
            drive_beat(stim_q[i]);
        end
        drive_idle();
        stim_q.delete();
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic clear_all();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        abort_pulses = 0;
        exp_aborts = 0;
    endtask

    function automatic vec_t mk(input string nm, input logic [63:0] m, input int n, input int gap,
                                input int x0, input int x1, input int y0, input int y1,
                                input int c, input bit f, input bit e);
        vec_t v;
        v.name = nm; v.mask = m; v.n = n; v.gap = gap;
        v.exp.x_min = x0; v.exp.x_max = x1; v.exp.y_min = y0; v.exp.y_max = y1;
        v.exp.cnt = c; v.exp.found = f; v.exp.err = e;
        return v;
    endfunction

    initial begin
        logic [63:0] m_t1, m_roi, m_ovr, m;
        m_t1  = (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 21);
        m_roi = (64'd1 << 0) | (64'd1 << 31) | (64'd1 << 20) | (64'd1 << 11);
        m_ovr = (64'd1 << 9) | (64'd1 << 30) | (64'd1 << 33);

        vt[0] = mk("three_edges", m_t1, 32, 0, 2, 5, 1, 2, 3, 1, 0);
        vt[1] = mk("all_zero", 64'd0, 32, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[2] = mk("early_eop", 64'd1 << 9, 21, 0, 0, 0, 0, 0, 1, 0, 1);
        vt[7] = mk("three_edges_gapped", m_t1, 32, 1, 2, 5, 1, 2, 3, 1, 0);
`ifdef EDGE_BBOX_ROI_EN
        vt[3] = mk("roi_pattern", m_roi, 32, 0, 3, 4, 1, 2, 2, 1, 0);
        vt[4] = mk("full_edges", 64'hFFFF_FFFF, 32, 0, 1, 6, 1, 2, 12, 1, 0);
        vt[5] = mk("one_pixel", 64'd1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[6] = mk("overrun", m_ovr, 36, 0, 0, 0, 0, 0, 1, 0, 1);
`else
        vt[3] = mk("roi_pattern", m_roi, 32, 0, 0, 7, 0, 3, 4, 1, 0);
        vt[4] = mk("full_edges", 64'hFFFF_FFFF, 32, 0, 0, 7, 0, 3, 32, 1, 0);
        vt[5] = mk("one_pixel", 64'd1, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        vt[6] = mk("overrun", m_ovr, 36, 0, 1, 6, 1, 3, 2, 1, 1);
`endif

        bus.din = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0; bus.din_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        foreach (vt[i]) begin
            clear_all();
            push_frame(vt[i].mask, vt[i].n, 1'b1);
            run_stim(vt[i].gap);
            settle();
            check($sformatf("%s.publish_count", vt[i].name), got_q.size(), 1);
            if (got_q.size() > 0) begin
                check_res(vt[i].name, got_q[0], vt[i].exp);
                if (vt[i].gap == 0)
                    check($sformatf("%s.latency", vt[i].name), got_cyc[0] - last_eop_cyc, 2);
            end
            check($sformatf("%s.abort_pulses", vt[i].name), abort_pulses, 0);
        end

        // sop re-asserted at pixel 10 aborts the first frame without a publish
        clear_all();
        push_frame(m_roi, 10, 1'b0);
        push_frame(m_t1, 32, 1'b1);
        run_stim(0);
        settle();
        check("abort.err_pulses", abort_pulses, 1);
        check("abort.publish_count", got_q.size(), 1);
        if (got_q.size() > 0) check_res("abort", got_q[0], vt[0].exp);

        // second sop lands in the DONE cycle of the first frame
        clear_all();
        push_frame(m_t1, 32, 1'b1);
        push_frame(m_roi, 32, 1'b1);
        run_stim(1);
        settle();
        check("b2b.publish_count", got_q.size(), 2);
        check("b2b.abort_pulses", abort_pulses, 0);
        if (got_q.size() > 1) begin
            check_res("b2b0", got_q[0], vt[0].exp);
            check_res("b2b1", got_q[1], vt[3].exp);
        end

        // reset in the middle of a frame
        clear_all();
        push_frame(m_t1, 15, 1'b0);
        run_stim(0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.din_vld = 1'b0;
        #2;
        check_zero("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        settle();
        check("mid_reset.publish_count", got_q.size(), 0);
        push_frame(m_t1, 32, 1'b1);
        run_stim(0);
        settle();
        check("post_reset.publish_count", got_q.size(), 1);
        check("post_reset.abort_pulses", abort_pulses, 0);
        if (got_q.size() > 0) check_res("post_reset", got_q[0], vt[0].exp);

        // randomized stream against the frame model
        clear_all();
        for (int f = 0; f < 40; f++) begin
            int k, n;
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                beat_t b;
                b.din = 1'($urandom_range(0, 1));
                b.sop = 1'b0;
                b.eop = 1'($urandom_range(0, 1));
                stim_q.push_back(b);
            end
            if ($urandom_range(0, 6) == 0) begin
                m = {$urandom, $urandom};
                push_frame(m, $urandom_range(1, 20), 1'b0);
            end
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 32;
            m = {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) m = m & {$urandom, $urandom} & {$urandom, $urandom};
            push_frame(m, n, 1'b1);
        end
        model_run(stim_q);
        run_stim(2);
        settle();
        check("rand.publish_count", got_q.size(), exp_q.size());
        check("rand.abort_pulses", abort_pulses, exp_aborts);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_res($sformatf("rand%0d", i), got_q[i], exp_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
